key_debounce_pulse: RTL and testbench

//  Front-end conditioner for the DE-board push-buttons. Synchronises the raw

---
 rtl/key_debounce_pulse.sv | 198 +++++++++++++++++++
 tb/tb_key_debounce_pulse.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, per-key debounce FSM,
// single-cycle press/release strobes and optional auto-repeat press strobes.
module key_debounce_pulse #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic [NUM_KEYS-1:0]   key_n,
    input  logic [NUM_KEYS-1:0]   repeat_en,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic [NUM_KEYS-1:0]   key_press,
    output logic [NUM_KEYS-1:0]   key_release,
    output logic [3*NUM_KEYS-1:0] key_state
);

    typedef enum logic [2:0] {
        S_RELEASED     = 3'd0,
        S_PRESS_WAIT   = 3'd1,
        S_HELD         = 3'd2,
        S_REPEATING    = 3'd3,
        S_RELEASE_WAIT = 3'd4
    } key_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    // With a one-cycle debounce the wait states are skipped entirely.
    localparam bit DB_SINGLE = (DEBOUNCE_CYCLES == 1);

    logic [NUM_KEYS-1:0] sync_s1;
    logic [NUM_KEYS-1:0] sync_s2;
    logic [NUM_KEYS-1:0] sync_p;

    // Stages reset to 1 so a key held through reset is seen as a fresh press.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '1;
            sync_s2 <= '1;
        end else begin
            sync_s1 <= key_n;
            sync_s2 <= sync_s1;
        end
    end

    assign sync_p = ~sync_s2;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_state_e       state_q;
        key_state_e       state_d;
        logic [CNT_W-1:0] db_cnt_q;
        logic [CNT_W-1:0] db_cnt_d;
        logic [CNT_W-1:0] rep_cnt_q;
        logic [CNT_W-1:0] rep_cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             db_done;
        logic             rep_done;

        assign db_done  = (db_cnt_q == DB_LAST);
        assign rep_done = (rep_cnt_q == ((state_q == S_HELD) ? DELAY_LAST : RATE_LAST));

        always_ff @(posedge CLOCK_50 or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= S_RELEASED;
                db_cnt_q  <= '0;
                rep_cnt_q <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                rep_cnt_q <= rep_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                S_RELEASED: begin
                    if (sync_p[k]) state_d = DB_SINGLE ? S_HELD : S_PRESS_WAIT;
                end
                S_PRESS_WAIT: begin
                    if (!sync_p[k])   state_d = S_RELEASED;
                    else if (db_done) state_d = S_HELD;
                end
                S_HELD: begin
                    if (!sync_p[k])                   state_d = DB_SINGLE ? S_RELEASED : S_RELEASE_WAIT;
                    else if (repeat_en[k] && rep_done) state_d = S_REPEATING;
                end
                S_REPEATING: begin
                    if (!sync_p[k])         state_d = DB_SINGLE ? S_RELEASED : S_RELEASE_WAIT;
                    else if (!repeat_en[k]) state_d = S_HELD;
                end
                S_RELEASE_WAIT: begin
                    if (sync_p[k])    state_d = S_HELD;
                    else if (db_done) state_d = S_RELEASED;
                end
                default: state_d = S_RELEASED;
            endcase
        end

        always_comb begin
            db_cnt_d  = db_cnt_q;
            rep_cnt_d = rep_cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                S_RELEASED: begin
                    level_d   = 1'b0;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                    if (sync_p[k]) begin
                        if (DB_SINGLE) begin
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            db_cnt_d = CNT_ONE;
                        end
                    end
                end
                S_PRESS_WAIT: begin
                    level_d = 1'b0;
                    if (!sync_p[k]) begin
                        db_cnt_d = '0;
                    end else if (db_done) begin
                        db_cnt_d  = '0;
                        rep_cnt_d = '0;
                        level_d   = 1'b1;
                        press_d   = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_ONE;
                    end
                end
                S_HELD, S_REPEATING: begin
                    level_d = 1'b1;
                    if (!sync_p[k]) begin
                        rep_cnt_d = '0;
                        if (DB_SINGLE) begin
                            db_cnt_d  = '0;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            db_cnt_d = CNT_ONE;
                        end
                    end else if (!repeat_en[k]) begin
                        rep_cnt_d = '0;
                    end else if (rep_done) begin
                        rep_cnt_d = '0;
                        press_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end
                S_RELEASE_WAIT: begin
                    level_d = 1'b1;
                    if (sync_p[k]) begin
                        db_cnt_d  = '0;
                        rep_cnt_d = '0;
                    end else if (db_done) begin
                        db_cnt_d  = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                    level_d   = 1'b0;
                end
            endcase
        end

        assign key_level[k]       = level_q;
        assign key_press[k]       = press_q;
        assign key_release[k]     = release_q;
        assign key_state[3*k +: 3] = state_q;

        a_strobe_exclusive: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            !(press_q && release_q));
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: directed key scenarios plus random bouncing,
// all outputs compared every cycle against a run-length reference model.
module tb_key_debounce_pulse;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int RD = 40;
    localparam int RR = 10;
    localparam int CW = 16;

    logic            CLOCK_50 = 1'b0;
    logic            reset_n  = 1'b0;
    logic [NK-1:0]   key_n     = '1;
    logic [NK-1:0]   repeat_en = '0;
    logic [NK-1:0]   key_level;
    logic [NK-1:0]   key_press;
    logic [NK-1:0]   key_release;
    logic [3*NK-1:0] key_state;

    int total = 0;
    int bad   = 0;

    // Expected {level, press, release} per clock edge.
    logic [3*NK-1:0] exp_q[$];

    key_debounce_pulse #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .CNT_W(CW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key_n(key_n),
        .repeat_en(repeat_en), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_state(key_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level flips after DB consecutive synchronised samples
    // disagreeing with it; repeats count enabled, undisturbed held cycles.
    logic [NK-1:0] hist_q[$];
    int m_run[NK];
    int m_elapsed[NK];
    bit m_lvl[NK];
    bit m_rep[NK];

    always @(posedge CLOCK_50) begin
        logic [NK-1:0] sp;
        logic [NK-1:0] lv;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        pr = '0;
        rl = '0;
        if (!reset_n) begin
            hist_q.delete();
            hist_q.push_back('1);
            hist_q.push_back('1);
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0; m_elapsed[k] = 0; m_lvl[k] = 0; m_rep[k] = 0;
            end
        end else begin
            sp = ~hist_q.pop_front();
            hist_q.push_back(key_n);
            for (int k = 0; k < NK; k++) begin
                if (sp[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_lvl[k] = sp[k];
                        m_run[k] = 0;
                        m_elapsed[k] = 0;
                        m_rep[k] = 0;
                        if (sp[k]) pr[k] = 1'b1;
                        else       rl[k] = 1'b1;
                    end
                end else if (m_run[k] != 0) begin
                    m_run[k] = 0;
                    m_elapsed[k] = 0;
                    m_rep[k] = 0;
                end else if (m_lvl[k]) begin
                    if (!repeat_en[k]) begin
                        m_elapsed[k] = 0;
                        m_rep[k] = 0;
                    end else begin
                        m_elapsed[k]++;
                        if (m_elapsed[k] == (m_rep[k] ? RR : RD)) begin
                            pr[k] = 1'b1;
                            m_elapsed[k] = 0;
                            m_rep[k] = 1;
                        end
                    end
                end
            end
        end
        for (int k = 0; k < NK; k++) lv[k] = m_lvl[k];
        exp_q.push_back({lv, pr, rl});
    end

    always @(negedge CLOCK_50) begin
        logic [3*NK-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("model_level",   32'(key_level),   32'(e[3*NK-1:2*NK]));
            check_eq("model_press",   32'(key_press),   32'(e[2*NK-1:NK]));
            check_eq("model_release", 32'(key_release), 32'(e[NK-1:0]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_level",   32'(key_level),   32'd0);
        check_eq("rst_press",   32'(key_press),   32'd0);
        check_eq("rst_release", 32'(key_release), 32'd0);
        check_eq("rst_state",   32'(key_state),   32'd0);
        reset_n = 1'b1;
        idle(5);

        // Clean press on key 0: strobe 9 edges after the first low sample.
        key_n[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            check_eq("k0_press", 32'(key_press[0]), 32'(i == 9));
        end
        check_eq("k0_level", 32'(key_level[0]), 32'd1);
        check_eq("k0_others", 32'(key_level[NK-1:1]), 32'd0);
        key_n[0] = 1'b1;
        idle(15);

        // Key 1 bounces shorter than the debounce window.
        for (int i = 0; i < 40; i++) begin
            key_n[1] = !((i < 5) || (i >= 7 && i < 12));
            @(negedge CLOCK_50);
            check_eq("k1_bounce_press", 32'(key_press[1]), 32'd0);
            check_eq("k1_bounce_level", 32'(key_level[1]), 32'd0);
        end

        // Key 2 held 100 cycles with auto-repeat.
        repeat_en[2] = 1'b1;
        key_n[2] = 1'b0;
        for (int i = 0; i < 121; i++) begin
            @(negedge CLOCK_50);
            check_eq("k2_rep_press", 32'(key_press[2]),
                     32'((i == 9) || (i >= 49 && i <= 99 && (i - 49) % 10 == 0)));
            check_eq("k2_rep_release", 32'(key_release[2]), 32'(i == 109));
            if (i == 99) key_n[2] = 1'b1;
        end
        idle(5);

        // Repeat disabled mid-stream, re-enabled: full delay restarts.
        key_n[2] = 1'b0;
        for (int i = 0; i < 146; i++) begin
            @(negedge CLOCK_50);
            check_eq("k2_toggle_press", 32'(key_press[2]),
                     32'(i == 9 || i == 49 || i == 59 || i == 115 || i == 125));
            check_eq("k2_toggle_release", 32'(key_release[2]), 32'(i == 139));
            if (i == 65)  repeat_en[2] = 1'b0;
            if (i == 75)  repeat_en[2] = 1'b1;
            if (i == 129) key_n[2] = 1'b1;
        end
        repeat_en[2] = 1'b0;
        idle(5);

        // Keys 0 and 3 fall together.
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLOCK_50);
            check_eq("k03_same_cycle", 32'({key_press[3], key_press[0]}),
                     (i == 9) ? 32'd3 : 32'd0);
        end
        key_n[0] = 1'b1;
        key_n[3] = 1'b1;
        idle(15);

        // Reset while key 1 is held: immediate clear, then a fresh press.
        key_n[1] = 1'b0;
        idle(12);
        check_eq("k1_held_level", 32'(key_level[1]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_level",   32'(key_level),   32'd0);
        check_eq("async_rst_press",   32'(key_press),   32'd0);
        check_eq("async_rst_release", 32'(key_release), 32'd0);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLOCK_50);
            check_eq("k1_post_rst_press", 32'(key_press[1]), 32'(i == 9));
        end
        key_n[1] = 1'b1;
        idle(15);

        // Random bouncing at several flip rates, with one mid-run reset.
        for (int ph = 0; ph < 6; ph++) begin
            int unsigned pct;
            pct = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 6 : 25);
            for (int c = 0; c < 600; c++) begin
                for (int k = 0; k < NK; k++) begin
                    if ($urandom_range(99, 0) < pct) key_n[k] = ~key_n[k];
                    if ($urandom_range(99, 0) < 2)   repeat_en[k] = ~repeat_en[k];
                end
                @(negedge CLOCK_50);
            end
            if (ph == 3) begin
                #3 reset_n = 1'b0;
                repeat (2) @(negedge CLOCK_50);
                reset_n = 1'b1;
            end
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
